exu_pipe: RTL
=============

Name: exu_pipe

Overview:
- Parametrised execute stage that takes one decoded integer op per handshake and returns a registered writeback result.
- The single-cycle ALU path and the multi-cycle MUL/DIV path share one issue port and one result port.
- Sits between the issue stage and writeback/bypass.
- Generalises the earlier unit-select stub: configurable XLEN, RV64 word ops, iterative divider, fixed-latency multiplier, valid/ready flow control and flush.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64; word ops are only meaningful at 64.
- MUL_LAT, 3, cycles spent in MUL state; minimum 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  kill the in-flight op and the held result; highest priority after reset.
- in_valid  in  1  op offered.
- in_ready  out  1  op accepted when in_valid & in_ready.
- in_rd  in  5  destination logical register.
- in_need_to_wb  in  1  result is written back.
- in_src1  in  XLEN  operand 1.
- in_src2  in  XLEN  operand 2 (register value).
- in_imm  in  XLEN  sign-extended immediate.
- in_is_imm  in  1  op2 = in_imm, else in_src2.
- in_alu_type  in  4  0 none, 1 ADD, 2 SUB, 3 SLL, 4 SLT, 5 SLTU, 6 XOR, 7 SRL, 8 SRA, 9 OR, 10 AND.
- in_muldiv_type  in  4  0 none, 1 MUL, 2 MULH, 3 MULHSU, 4 MULHU, 5 DIV, 6 DIVU, 7 REM, 8 REMU.
- in_is_word  in  1  RV64 *W form.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes the result.
- out_rd  out  5  captured in_rd.
- out_need_to_wb  out  1  captured in_need_to_wb.
- out_result  out  XLEN  result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE; out_valid, out_rd, out_need_to_wb, out_result, busy, counter all 0.
- States: IDLE, MUL, DIV.
- Issue rule: in_ready = (state==IDLE) & (!out_valid | out_ready). Accept = in_valid & in_ready.
- Muldiv and ALU are mutually exclusive on a given op. If in_muldiv_type!=0, the muldiv path is taken. If both type fields are 0, the op still completes as ALU with result 0 (used for pass-through/nop).
- ALU path: result is registered, so out_valid rises the cycle after accept.
- Word ops (in_is_word=1): operands are taken from bits [31:0]; shift amount is op2[4:0] (otherwise [log2 XLEN-1:0]); the 32-bit result is sign-extended to XLEN.
- SLT/SLTU produce 0 or 1.
- MUL: accept at T moves to MUL and loads counter=MUL_LAT-1.
  - Counter decrements each cycle; at 0 the result is written, state returns to IDLE, and out_valid=1 at T+MUL_LAT+1.
  - MULH* return the upper XLEN bits of the 2*XLEN product with the stated signedness.
  - MULW returns the sign-extended low 32 bits.
- DIV/REM, special cases resolved in 1 cycle (ALU latency, no DIV state):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - Signed overflow (most-negative / -1): DIV gives the dividend; REM gives 0.
  - The W forms apply these rules on 32-bit values.
- DIV/REM, normal case: radix-2 restoring division on magnitudes.
  - Runs W iterations, where W=32 for word ops and XLEN otherwise.
  - out_valid at T+W+1.
  - Signs are fixed up at the end: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
- Result hold: out_* stay stable while out_valid & !out_ready. A new result may load on the same cycle the old one is taken.
- Flush: next cycle state=IDLE and out_valid=0. A concurrent accept is dropped, and in_ready is forced 0 while flush=1.
- Reset mid-operation: same effect as flush, plus all registers are cleared.

Test Plan:
- ALU ADD src1=5, imm=-3, is_imm=1, rd=7 -> out_valid next cycle; out_result=2, out_rd=7. Back-to-back ADD/XOR with out_ready=1 -> one result per cycle.
- MUL, MUL_LAT=3: 0xFFFF_FFFF_FFFF_FFFF × 2 accepted at T -> out_valid at T+4. Value is 0xFFFF_FFFF_FFFF_FFFE; MULHU of the same operands gives 1. busy=1 during T+1..T+3 and in_ready=0.
- DIV -7/2 -> quotient -3; REM -> -1. out_valid at T+65 for XLEN=64 and at T+33 for DIVW.
- DIV 9/0 -> 0xFFFF_FFFF_FFFF_FFFF one cycle after accept. REMU 9/0 -> 9. DIV 0x8000_0000_0000_0000/-1 -> 0x8000_0000_0000_0000.
- Backpressure: hold out_ready=0 for 5 cycles after an ALU result -> out_result stable and in_ready=0. Raising out_ready with in_valid high -> the old result is taken and the new op is accepted in the same cycle.
- flush asserted at cycle 10 of a DIV -> busy=0 and out_valid=0 the next cycle, and no result ever appears. Repeat with reset instead -> all outputs 0.

Source files
------------

// File: rtl/exu_pipe.sv
// Integer execute stage: single-cycle ALU plus fixed-latency multiplier and
// iterative restoring divider, sharing one valid/ready issue port and result register.
module exu_pipe #(
  parameter int XLEN    = 64,
  parameter int MUL_LAT = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic            in_need_to_wb,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_is_imm,
  input  logic [3:0]      in_alu_type,
  input  logic [3:0]      in_muldiv_type,
  input  logic            in_is_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic            out_need_to_wb,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int SH_W    = $clog2(XLEN);
  localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  function automatic logic [XLEN-1:0] alu_op(input logic [3:0] t, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b, input logic w);
    logic [31:0] a32;
    logic [31:0] b32;
    logic signed [31:0] sa32;
    logic signed [XLEN-1:0] sa;
    a32  = a[31:0];
    b32  = b[31:0];
    sa32 = a32;
    sa   = a;
    case (t)
      4'd1:    return w ? sext32(a32 + b32) : a + b;
      4'd2:    return w ? sext32(a32 - b32) : a - b;
      4'd3:    return w ? sext32(a32 << b32[4:0]) : a << b[SH_W-1:0];
      4'd4:    return ($signed(a) < $signed(b)) ? XLEN'(1) : '0;
      4'd5:    return (a < b) ? XLEN'(1) : '0;
      4'd6:    return a ^ b;
      4'd7:    return w ? sext32(a32 >> b32[4:0]) : a >> b[SH_W-1:0];
      4'd8:    return w ? sext32($unsigned(sa32 >>> b32[4:0])) : $unsigned(sa >>> b[SH_W-1:0]);
      4'd9:    return a | b;
      4'd10:   return a & b;
      default: return '0;
    endcase
  endfunction

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [XLEN-1:0]   opa_p1, opb_p1, rem_p1;
  logic [3:0]        type_p1;
  logic              word_p1, neg_q_p1, neg_r_p1, wb_p1;
  logic [4:0]        rd_p1;

  logic [XLEN-1:0]   op2, dv, ds, mag_a, mag_b, quo_init, fast_res, raw_fast, issue_res;
  logic              is_mul, is_div, div_signed, is_rem, div_zero, div_min, div_ovf, div_fast;
  logic              single, acc;

  // Issue stage: operand select, single-cycle results and divider setup
  always_comb begin
    op2        = in_is_imm ? in_imm : in_src2;
    is_mul     = (in_muldiv_type >= 4'd1) && (in_muldiv_type <= 4'd4);
    is_div     = (in_muldiv_type >= 4'd5) && (in_muldiv_type <= 4'd8);
    div_signed = (in_muldiv_type == 4'd5) || (in_muldiv_type == 4'd7);
    is_rem     = (in_muldiv_type == 4'd7) || (in_muldiv_type == 4'd8);
    dv         = in_src1;
    ds         = op2;
    div_min    = (in_src1 == {1'b1, {(XLEN-1){1'b0}}});
    if (in_is_word) begin
      dv      = div_signed ? sext32(in_src1[31:0]) : XLEN'(in_src1[31:0]);
      ds      = div_signed ? sext32(op2[31:0]) : XLEN'(op2[31:0]);
      div_min = (in_src1[31:0] == 32'h8000_0000);
    end
    div_zero = (ds == '0);
    div_ovf  = div_signed && div_min && (ds == '1);
    div_fast = div_zero || div_ovf;
    if (div_zero) raw_fast = is_rem ? dv : '1;
    else          raw_fast = is_rem ? '0 : dv;
    fast_res  = in_is_word ? sext32(raw_fast[31:0]) : raw_fast;
    mag_a     = (div_signed && dv[XLEN-1]) ? -dv : dv;
    mag_b     = (div_signed && ds[XLEN-1]) ? -ds : ds;
    quo_init  = in_is_word ? (mag_a << (XLEN - 32)) : mag_a;
    issue_res = (in_muldiv_type == 4'd0) ? alu_op(in_alu_type, in_src1, op2, in_is_word)
                                         : (is_div ? fast_res : '0);
    single    = !is_mul && !(is_div && !div_fast);
    in_ready  = (state == IDLE) && (!out_valid || out_ready) && !flush;
    acc       = in_valid && in_ready;
    busy      = (state != IDLE);
  end

  logic signed [2*XLEN-1:0] ea, eb, prod;
  logic [XLEN-1:0]          mul_res, quo_nx, rem_nx, q_fin, r_fin, sel_res, div_res;
  logic [XLEN:0]            rem_sh, diff;

  // Multi-cycle stage: multiplier product and one restoring-division step
  always_comb begin
    ea      = {{XLEN{((type_p1 == 4'd2) || (type_p1 == 4'd3)) && opa_p1[XLEN-1]}}, opa_p1};
    eb      = {{XLEN{(type_p1 == 4'd2) && opb_p1[XLEN-1]}}, opb_p1};
    prod    = ea * eb;
    if (type_p1 == 4'd1) mul_res = word_p1 ? sext32(prod[31:0]) : prod[XLEN-1:0];
    else                 mul_res = prod[2*XLEN-1:XLEN];
    rem_sh  = {rem_p1, opa_p1[XLEN-1]};
    diff    = rem_sh - {1'b0, opb_p1};
    if (!diff[XLEN]) begin
      rem_nx = diff[XLEN-1:0];
      quo_nx = {opa_p1[XLEN-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[XLEN-1:0];
      quo_nx = {opa_p1[XLEN-2:0], 1'b0};
    end
    q_fin   = neg_q_p1 ? -quo_nx : quo_nx;
    r_fin   = neg_r_p1 ? -rem_nx : rem_nx;
    sel_res = ((type_p1 == 4'd7) || (type_p1 == 4'd8)) ? r_fin : q_fin;
    div_res = word_p1 ? sext32(sel_res[31:0]) : sel_res;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (acc && is_mul) begin
          state_nx = MUL;
          cnt_nx   = CNT_W'(MUL_LAT - 1);
        end else if (acc && is_div && !div_fast) begin
          state_nx = DIV;
          cnt_nx   = in_is_word ? CNT_W'(31) : CNT_W'(XLEN - 1);
        end
      end
      MUL, DIV: begin
        if (cnt == '0) state_nx = IDLE;
        else           cnt_nx   = cnt - 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // Writeback stage: result register with hold under backpressure
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      out_valid      <= 1'b0;
      out_rd         <= '0;
      out_need_to_wb <= 1'b0;
      out_result     <= '0;
      opa_p1         <= '0;
      opb_p1         <= '0;
      rem_p1         <= '0;
      type_p1        <= '0;
      word_p1        <= 1'b0;
      neg_q_p1       <= 1'b0;
      neg_r_p1       <= 1'b0;
      rd_p1          <= '0;
      wb_p1          <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (acc && single) begin
        out_valid      <= 1'b1;
        out_result     <= issue_res;
        out_rd         <= in_rd;
        out_need_to_wb <= in_need_to_wb;
      end else if (state != IDLE && cnt == '0) begin
        out_valid      <= 1'b1;
        out_result     <= (state == MUL) ? mul_res : div_res;
        out_rd         <= rd_p1;
        out_need_to_wb <= wb_p1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (acc) begin
        type_p1  <= in_muldiv_type;
        word_p1  <= in_is_word;
        rd_p1    <= in_rd;
        wb_p1    <= in_need_to_wb;
        neg_q_p1 <= div_signed && (dv[XLEN-1] != ds[XLEN-1]);
        neg_r_p1 <= div_signed && dv[XLEN-1];
        rem_p1   <= '0;
        opa_p1   <= is_div ? quo_init : in_src1;
        opb_p1   <= is_div ? mag_b : op2;
      end else if (state == DIV) begin
        opa_p1 <= quo_nx;
        rem_p1 <= rem_nx;
      end
    end
  end

endmodule
